// File: rtl/freq_loop_ctrl.sv
// freq_loop_ctrl
//   Drives a DAC0832 through a four-state write sequencer. In manual mode the
//   DAC code follows the switch value. In auto mode each frequency measurement
//   moves the code one STEP toward the target frequency. A lock indicator is
//   raised after LOCK_CNT consecutive in-tolerance measurements.
//
// Ports
//   clk        100 MHz system clock
//   rst        synchronous active-high reset
//   mode       0 = manual (code follows sw), 1 = auto (closed loop)
//   sw         manual DAC code, debounced upstream
//   target     auto-mode target frequency, Hz
//   freq       latest measured frequency, Hz
//   meas_valid one-clk pulse: freq has just been updated
//   dac_data   DAC DI7..DI0
//   dac_cs     DAC chip select, active low
//   dac_wr1    DAC input-latch write, active low
//   dac_wr2    DAC DAC-latch write, active low
//   busy       write sequencer not idle
//   locked     auto mode has converged
//   code       committed DAC code
module freq_loop_ctrl #(
  parameter int unsigned WR_LOW   = 10,
  parameter int unsigned TOL      = 16,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned STEP     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic [7:0]  sw,
  input  logic [15:0] target,
  input  logic [15:0] freq,
  input  logic        meas_valid,
  output logic [7:0]  dac_data,
  output logic        dac_cs,
  output logic        dac_wr1,
  output logic        dac_wr2,
  output logic        busy,
  output logic        locked,
  output logic [7:0]  code
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [7:0]         WR_LAST  = 8'(WR_LOW - 1);
  localparam logic signed [16:0] TOL_POS  = 17'(TOL);
  localparam logic signed [16:0] TOL_NEG  = -TOL_POS;
  localparam logic [8:0]         STEP_W   = 9'(STEP);
  localparam logic [3:0]         LOCK_LIM = 4'(LOCK_CNT);
  localparam logic [7:0]         INIT_CODE = 8'h80;

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;

  logic        pend;
  logic [7:0]  new_code;
  logic        init_req;
  logic        meas_pend;
  logic [15:0] meas_freq;
  logic [7:0]  sw_q;
  logic        mode_q;
  logic [15:0] target_q;
  logic [3:0]  lock_cnt;

  logic signed [16:0] live_err;
  logic signed [16:0] pend_err;
  logic               live_in_tol;
  logic [8:0]         up_sum;
  logic [7:0]         up_code;
  logic [7:0]         dn_code;
  logic [7:0]         auto_code;
  logic               idle_free;

  // ---------------------------------------------------------------------------
  // Write sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else                     cnt <= cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write sequencer: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (pend)            state_next = SETUP;
      SETUP:  if (cnt == 8'd1)     state_next = STROBE;
      STROBE: if (cnt == WR_LAST)  state_next = HOLD;
      HOLD:   if (cnt == 8'd1)     state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write sequencer: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    dac_cs  = 1'b1;
    dac_wr1 = 1'b1;
    dac_wr2 = 1'b1;
    unique case (state)
      SETUP, HOLD: dac_cs = 1'b0;
      STROBE: begin
        dac_cs  = 1'b0;
        dac_wr1 = 1'b0;
        dac_wr2 = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy   = (state != IDLE);
  assign locked = mode && (lock_cnt == LOCK_LIM);

  // ---------------------------------------------------------------------------
  // Error and saturating code arithmetic
  // ---------------------------------------------------------------------------
  always_comb begin
    live_err    = $signed({1'b0, freq})      - $signed({1'b0, target});
    pend_err    = $signed({1'b0, meas_freq}) - $signed({1'b0, target});
    live_in_tol = !(live_err > TOL_POS) && !(live_err < TOL_NEG);

    up_sum  = {1'b0, code} + STEP_W;
    up_code = up_sum[8] ? 8'hFF : up_sum[7:0];
    dn_code = ({1'b0, code} < STEP_W) ? 8'h00 : (code - STEP_W[7:0]);

    if (pend_err < TOL_NEG)      auto_code = up_code;
    else if (pend_err > TOL_POS) auto_code = dn_code;
    else                         auto_code = code;

    idle_free = (state == IDLE) && !pend;
  end

  // ---------------------------------------------------------------------------
  // Request generation, committed code, lock counter
  // ---------------------------------------------------------------------------
  // A measurement only captures freq; the step is decided on the first free
  // IDLE cycle against the code committed by then, so a newer pulse simply
  // replaces the captured freq (single-entry, newest wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_data  <= INIT_CODE;
      code      <= INIT_CODE;
      pend      <= 1'b0;
      new_code  <= INIT_CODE;
      init_req  <= 1'b1;
      meas_pend <= 1'b0;
      meas_freq <= '0;
      sw_q      <= INIT_CODE;
      mode_q    <= mode;
      target_q  <= target;
      lock_cnt  <= '0;
    end else begin
      sw_q     <= sw;
      mode_q   <= mode;
      target_q <= target;
      init_req <= 1'b0;

      if ((state == IDLE) && pend) begin
        dac_data <= new_code;
        pend     <= 1'b0;
      end

      if ((state == HOLD) && (state_next == IDLE)) code <= dac_data;

      if (!mode && idle_free && (sw_q != code)) begin
        pend     <= 1'b1;
        new_code <= sw_q;
      end

      // Skipped when a fresh pulse arrives this cycle so it supersedes the
      // captured one instead of queuing behind it.
      if (mode && idle_free && meas_pend && !meas_valid) begin
        meas_pend <= 1'b0;
        if (auto_code != code) begin
          pend     <= 1'b1;
          new_code <= auto_code;
        end
      end

      if (!mode) begin
        meas_pend <= 1'b0;
      end else if (meas_valid) begin
        meas_pend <= 1'b1;
        meas_freq <= freq;
      end

      if (init_req) begin
        pend     <= 1'b1;
        new_code <= INIT_CODE;
      end

      if ((mode != mode_q) || (target != target_q)) begin
        lock_cnt <= '0;
      end else if (mode && meas_valid) begin
        if (!live_in_tol)              lock_cnt <= '0;
        else if (lock_cnt != LOCK_LIM) lock_cnt <= lock_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_freq_loop_ctrl.sv
module tb_freq_loop_ctrl;

  localparam int WR_LOW   = 10;
  localparam int TOL      = 16;
  localparam int LOCK_CNT = 3;
  localparam int STEP     = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [7:0]  sw;
  logic [15:0] target;
  logic [15:0] freq;
  logic        meas_valid;
  logic [7:0]  dac_data;
  logic        dac_cs;
  logic        dac_wr1;
  logic        dac_wr2;
  logic        busy;
  logic        locked;
  logic [7:0]  code;

  freq_loop_ctrl #(
    .WR_LOW  (WR_LOW),
    .TOL     (TOL),
    .LOCK_CNT(LOCK_CNT),
    .STEP    (STEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sw        (sw),
    .target    (target),
    .freq      (freq),
    .meas_valid(meas_valid),
    .dac_data  (dac_data),
    .dac_cs    (dac_cs),
    .dac_wr1   (dac_wr1),
    .dac_wr2   (dac_wr2),
    .busy      (busy),
    .locked    (locked),
    .code      (code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction monitor: one record per chip-select-low window.
  int   wq_data[$];
  int   wq_cs[$];
  int   wq_wr[$];
  int   wq_stable[$];
  bit   in_tx = 1'b0;
  int   cs_len, wr_len;
  logic [7:0] d0;
  bit   stab;

  always @(negedge clk) begin
    if (dac_cs === 1'b0) begin
      if (!in_tx) begin
        in_tx  = 1'b1;
        cs_len = 0;
        wr_len = 0;
        d0     = dac_data;
        stab   = 1'b1;
      end
      cs_len++;
      if (dac_wr1 === 1'b0) wr_len++;
      if (dac_wr1 !== dac_wr2) stab = 1'b0;
      if (dac_data !== d0) stab = 1'b0;
    end else if (in_tx) begin
      in_tx = 1'b0;
      wq_data.push_back(int'(d0));
      wq_cs.push_back(cs_len);
      wq_wr.push_back(wr_len);
      wq_stable.push_back(int'(stab));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    wq_data.delete();
    wq_cs.delete();
    wq_wr.delete();
    wq_stable.delete();
  endtask

  task automatic expect_writes(input string tag, input int n, input int a, input int b);
    int e;
    chk({tag, "_count"}, wq_data.size(), n);
    for (int i = 0; i < n && i < wq_data.size(); i++) begin
      e = (i == 0) ? a : b;
      chk({tag, "_data"},   wq_data[i],   e);
      chk({tag, "_cs_len"}, wq_cs[i],     4 + WR_LOW);
      chk({tag, "_wr_len"}, wq_wr[i],     WR_LOW);
      chk({tag, "_stable"}, wq_stable[i], 1);
    end
    clear_q();
  endtask

  task automatic meas(input int f);
    freq       = 16'(f);
    meas_valid = 1'b1;
    step();
    meas_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    int k = 0;
    while (dac_wr1 !== 1'b0 && k < 60) begin
      step();
      k++;
    end
    chk({tag, "_strobe_seen"}, dac_wr1, 0);
  endtask

  // Put the DUT in manual mode at code c and leave the monitor empty.
  task automatic set_code(input int c);
    mode = 1'b0;
    sw   = 8'(c);
    settle(40);
    chk("set_code", code, c);
    clear_q();
  endtask

  // Reference for one auto-mode correction.
  function automatic int model_step(input int c, input int f, input int t);
    int err = f - t;
    if (err < -TOL) return (c + STEP > 255) ? 255 : c + STEP;
    if (err > TOL)  return (c < STEP) ? 0 : c - STEP;
    return c;
  endfunction

  initial begin
    int c, t, f, off, sel, e, s;

    rst = 1'b1; mode = 1'b0; sw = 8'h80; target = 16'd1000;
    freq = '0; meas_valid = 1'b0;
    settle(3);
    chk("rst_cs",   dac_cs,   1);
    chk("rst_wr1",  dac_wr1,  1);
    chk("rst_wr2",  dac_wr2,  1);
    chk("rst_busy", busy,     0);
    chk("rst_lock", locked,   0);
    chk("rst_code", code,     8'h80);
    chk("rst_data", dac_data, 8'h80);
    clear_q();

    // Initial DAC write after reset release
    rst = 1'b0;
    settle(30);
    expect_writes("init", 1, 8'h80, 0);
    chk("init_busy", busy, 0);
    chk("init_code", code, 8'h80);

    // Manual change then quiet
    sw = 8'h3C;
    settle(30);
    expect_writes("man", 1, 8'h3C, 0);
    chk("man_code", code, 8'h3C);
    settle(30);
    expect_writes("man_quiet", 0, 0, 0);

    // Manual mode ignores meas_valid
    meas(100);
    settle(30);
    expect_writes("man_meas", 0, 0, 0);

    // Auto single steps
    set_code(8'h80); mode = 1'b1; settle(2);
    meas(900);  settle(30);
    expect_writes("auto_up", 1, 8'h81, 0);
    set_code(8'h80); mode = 1'b1; settle(2);
    meas(1100); settle(30);
    expect_writes("auto_dn", 1, 8'h7F, 0);
    set_code(8'h80); mode = 1'b1; settle(2);
    meas(1010); settle(30);
    expect_writes("auto_tol", 0, 0, 0);
    chk("auto_tol_code", code, 8'h80);

    // Lock acquisition and loss
    set_code(8'h80); mode = 1'b1; settle(2);
    meas(995); settle(3); chk("lock_p1", locked, 0);
    meas(995); settle(3); chk("lock_p2", locked, 0);
    meas(995);            chk("lock_p3", locked, 1);
    settle(3);
    meas(1200);           chk("lock_lost", locked, 0);
    settle(30);
    expect_writes("lock_lost", 1, 8'h7F, 0);

    // Target change and mode toggle both clear the counter
    meas(1000); settle(2); meas(1000); settle(2); meas(1000); settle(2);
    chk("relock", locked, 1);
    target = 16'd1001; settle(2);
    chk("tgt_clear", locked, 0);
    target = 16'd1000; settle(2);
    meas(1000); settle(2); meas(1000); settle(2); meas(1000); settle(2);
    chk("relock2", locked, 1);
    mode = 1'b0; step(); mode = 1'b1; settle(2);
    chk("mode_clear", locked, 0);
    settle(30);
    clear_q();

    // Rails
    set_code(8'hFF); mode = 1'b1; settle(2);
    meas(100); settle(30);
    expect_writes("rail_hi", 0, 0, 0);
    chk("rail_hi_code", code, 8'hFF);
    set_code(8'h00); mode = 1'b1; settle(2);
    meas(5000); settle(30);
    expect_writes("rail_lo", 0, 0, 0);
    chk("rail_lo_code", code, 8'h00);

    // Two pulses during one STROBE: newest wins, evaluated after the write
    set_code(8'h80); mode = 1'b1; settle(2);
    meas(900);
    wait_strobe("ovw");
    meas(900); step(); meas(1100);
    settle(60);
    expect_writes("ovw", 2, 8'h81, 8'h80);
    chk("ovw_code", code, 8'h80);

    // Mode change does not abort a manual write
    set_code(8'h80);
    sw = 8'h20;
    wait_strobe("mchg");
    mode = 1'b1;
    settle(30);
    expect_writes("mchg", 1, 8'h20, 0);
    chk("mchg_code", code, 8'h20);

    // Manual request after switching away from auto mid-write
    set_code(8'h80); mode = 1'b1; settle(2);
    sw = 8'h50;
    meas(900);
    wait_strobe("a2m");
    mode = 1'b0;
    settle(60);
    expect_writes("a2m", 2, 8'h81, 8'h50);
    chk("a2m_code", code, 8'h50);

    // Reset during STROBE
    set_code(8'h80); mode = 1'b1; settle(2);
    meas(900);
    wait_strobe("rst_mid");
    rst = 1'b1;
    step();
    chk("rst_mid_cs",   dac_cs,   1);
    chk("rst_mid_wr1",  dac_wr1,  1);
    chk("rst_mid_wr2",  dac_wr2,  1);
    chk("rst_mid_data", dac_data, 8'h80);
    chk("rst_mid_code", code,     8'h80);
    settle(2);
    clear_q();
    rst = 1'b0;
    settle(30);
    expect_writes("rst_mid_init", 1, 8'h80, 0);

    // Randomized auto corrections around the tolerance band
    for (int i = 0; i < 20; i++) begin
      c = int'($urandom_range(0, 255));
      t = int'($urandom_range(1000, 3000));
      target = 16'(t);
      set_code(c);
      mode = 1'b1; settle(2);
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: off = -(TOL + 1);
        1: off = -TOL;
        2: off = TOL;
        3: off = TOL + 1;
        default: off = int'($urandom_range(0, 1800)) - 900;
      endcase
      f = t + off;
      meas(f);
      settle(30);
      e = model_step(c, f, t);
      expect_writes("rand_auto", (e != c) ? 1 : 0, e, 0);
      chk("rand_auto_code", code, e);
    end

    // Randomized manual codes
    set_code(8'h80);
    c = 8'h80;
    for (int i = 0; i < 8; i++) begin
      s = int'($urandom_range(0, 255));
      sw = 8'(s);
      settle(30);
      expect_writes("rand_man", (s != c) ? 1 : 0, s, 0);
      chk("rand_man_code", code, s);
      c = s;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/freq_loop_ctrl.md
FREQ_LOOP_CTRL -- requirements
Module: freq_loop_ctrl

Interface
REQ-001 Parameter WR_LOW: default 10; number of clk cycles the DAC write strobes are held low (legal range 1..255).
REQ-002 Parameter TOL: default 16; lock tolerance in Hz, unsigned 16 bit.
REQ-003 Parameter LOCK_CNT: default 3; consecutive in-tolerance measurements needed to assert locked (legal range 1..15).
REQ-004 Parameter STEP: default 1; DAC code increment or decrement per correction (legal range 1..255).
REQ-005 Port clk, input, 1 bit: 100 MHz system clock; the only clock.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port mode, input, 1 bit: 0 = manual (DAC code follows sw), 1 = auto (closed loop toward target).
REQ-008 Port sw, input, 8 bits: manual DAC code, already debounced upstream.
REQ-009 Port target, input, 16 bits: auto-mode target frequency in Hz.
REQ-010 Port freq, input, 16 bits: latest measured frequency in Hz.
REQ-011 Port meas_valid, input, 1 bit: one-clk pulse meaning freq has just been updated.
REQ-012 Port dac_data, output, 8 bits: DAC0832 DI7..DI0.
REQ-013 Port dac_cs, output, 1 bit: DAC chip select, active low.
REQ-014 Port dac_wr1, output, 1 bit: DAC input-latch write, active low.
REQ-015 Port dac_wr2, output, 1 bit: DAC DAC-latch write, active low.
REQ-016 Port busy, output, 1 bit: high whenever the write FSM is not in IDLE.
REQ-017 Port locked, output, 1 bit: high when auto mode has converged.
REQ-018 Port code, output, 8 bits: current committed DAC code, for display and LEDs.

Function
REQ-019 The block SHALL implement a write FSM with states IDLE, SETUP, STROBE and HOLD.
REQ-020 IDLE: if pend=1, the FSM SHALL latch new_code onto dac_data, clear pend, and go to SETUP.
REQ-021 SETUP: the FSM SHALL hold dac_cs=0 with both wr signals high for 2 cycles, then go to STROBE.
REQ-022 STROBE: the FSM SHALL hold dac_cs=0, dac_wr1=0 and dac_wr2=0 for exactly WR_LOW cycles, then go to HOLD.
REQ-023 HOLD: the FSM SHALL hold dac_cs=0 with both wr signals high for 2 cycles, set code to dac_data, then go to IDLE.
REQ-024 A full write transaction SHALL take 4+WR_LOW cycles from leaving IDLE to returning to IDLE.
REQ-025 dac_data SHALL remain stable from SETUP entry until IDLE is re-entered.
REQ-026 In manual mode, when the registered value of sw differs from code and no write is in flight, the block SHALL set pend=1 with new_code=sw.
REQ-027 In manual mode, meas_valid SHALL be ignored for code updates.
REQ-028 In auto mode, on each meas_valid the block SHALL compute err = freq - target as 17-bit signed.
REQ-029 In auto mode, if |err| <= TOL the code SHALL be held and no write issued.
REQ-030 In auto mode, if err < -TOL the block SHALL compute new_code = min(code+STEP, 255) using saturating arithmetic.
REQ-031 In auto mode, if err > TOL the block SHALL compute new_code = max(code-STEP, 0) using saturating arithmetic.
REQ-032 In auto mode, a write SHALL be issued only when new_code differs from code; at a rail, no write is issued.
REQ-033 If meas_valid arrives while busy=1, the block SHALL latch a single pending request evaluated against the freq captured at that pulse.
REQ-034 A later meas_valid during the same busy period SHALL overwrite the pending request (depth 1, newest wins).
REQ-035 The block SHALL serve the pending request on the first IDLE cycle.
REQ-036 A mode change SHALL clear locked and the lock counter, and SHALL NOT abort a write in flight.
REQ-037 A manual-mode request arising after a mode change SHALL be served after the write in flight completes.
REQ-038 A lock counter SHALL increment on each in-tolerance meas_valid, saturating at LOCK_CNT.
REQ-039 The lock counter SHALL clear on any out-of-tolerance meas_valid.
REQ-040 locked SHALL equal (mode=1 and lock counter = LOCK_CNT).
REQ-041 A change of target SHALL clear the lock counter on the next cycle.

Reset
REQ-042 While rst=1 at a rising clk edge, the block SHALL set: FSM=IDLE, dac_cs=1, dac_wr1=1, dac_wr2=1, dac_data=8'h80, code=8'h80, pend=0, lock counter=0, locked=0, busy=0.
REQ-043 Reset asserted mid-transaction SHALL abort the transaction, with strobes high on the same edge.
REQ-044 On the first cycle after rst is released, the block SHALL set pend=1 with new_code=8'h80 so the DAC is initialised.

Verification
REQ-045 Release reset, mode=0, sw=8'h80: one write of 0x80 occurs; dac_cs is low for 14 cycles and wr low for 10 cycles; busy falls; code=0x80.
REQ-046 mode=0, sw changes 0x80->0x3C: a write of 0x3C occurs; code=0x3C after 14 cycles; no further writes while sw is stable.
REQ-047 mode=1, target=1000, code=0x80, meas_valid with freq=900: a write of 0x81 occurs; with freq=1100 instead: a write of 0x7F occurs; with freq=1010: no write occurs.
REQ-048 mode=1, three meas_valid pulses with freq=995: locked rises on the third pulse; a fourth pulse with freq=1200 clears locked and writes code-1.
REQ-049 code=0xFF, mode=1, freq far below target: no write occurs and code stays 0xFF; with code=0x00 and freq far above target: no write occurs.
REQ-050 Two meas_valid pulses during one STROBE, freq=900 then freq=1100: after the current write ends, exactly one write occurs using freq=1100; assert rst during STROBE: on the next edge cs and wr are high and dac_data=0x80.
